// File: rtl/xls_fifo_wrapper_multi.sv
`default_nettype none
// ============================================================================
// Module   : xls_fifo_wrapper_multi
// Purpose  : Parametrised-depth circular-buffer channel FIFO placed between
//            XLS-generated procs. Ready/valid on both sides, with an optional
//            same-cycle bypass from push to pop while the FIFO is empty.
// Ports    : clk        - clock, all state updates on the rising edge
//            rst        - asynchronous, active-low reset
//            push_ready - FIFO can accept push_data this cycle
//            push_data  - data to enqueue (Width bits)
//            push_valid - producer offers push_data
//            pop_ready  - consumer accepts pop_data this cycle
//            pop_data   - head-of-queue data (Width bits)
//            pop_valid  - pop_data is valid
//            level      - registered occupancy (only with XLS_FIFO_LEVEL_EN)
// Options  : define XLS_FIFO_LEVEL_EN to add the level output port and the
//            simulation-only occupancy checks.
// Revision : 1.0 - initial release
// ============================================================================
module xls_fifo_wrapper_multi #(
   parameter  int Width        = 32,
   parameter  int Depth        = 4,
   parameter  int EnableBypass = 0,
   localparam int AddrWidth    = (Depth == 1) ? 1 : $clog2(Depth),
   localparam int CntWidth     = $clog2(Depth + 1)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                push_ready,
   input  logic [Width-1:0]    push_data,
   input  logic                push_valid,
   input  logic                pop_ready,
   output logic [Width-1:0]    pop_data,
   output logic                pop_valid
`ifdef XLS_FIFO_LEVEL_EN
   ,
   output logic [CntWidth-1:0] level
`endif
);

   localparam logic [CntWidth-1:0]  C_FULL   = CntWidth'(Depth);
   localparam logic [AddrWidth-1:0] C_LAST   = AddrWidth'(Depth - 1);
   localparam logic                 C_BYPASS = (EnableBypass != 0);

   logic [Width-1:0]     r_mem [Depth];
   logic [AddrWidth-1:0] r_wr_ptr;
   logic [AddrWidth-1:0] r_rd_ptr;
   logic [CntWidth-1:0]  r_count;

   logic w_empty;
   logic w_push_fire;
   logic w_pop_fire;
   logic w_pass;
   logic w_wr_en;
   logic w_rd_en;

   // Explicit wrap so non-power-of-2 depths never index past the last entry.
   function automatic logic [AddrWidth-1:0] next_ptr(input logic [AddrWidth-1:0] p);
      return (p == C_LAST) ? '0 : p + AddrWidth'(1);
   endfunction

   assign w_empty = (r_count == '0);

   // Both handshake outputs are forced low while reset is held, so the
   // channel looks idle to neighbours before the state is cleared/released.
   assign push_ready = rst && (r_count != C_FULL);
   assign pop_valid  = rst && (!w_empty || (C_BYPASS && push_valid));
   assign pop_data   = w_empty ? push_data : r_mem[r_rd_ptr];

   assign w_push_fire = push_valid && push_ready;
   assign w_pop_fire  = pop_valid && pop_ready;

   // A push and pop on an empty FIFO can only happen through the bypass:
   // the word goes straight across and storage is left untouched.
   assign w_pass  = w_empty && w_push_fire && w_pop_fire;
   assign w_wr_en = w_push_fire && !w_pass;
   assign w_rd_en = w_pop_fire && !w_pass;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_rd_en) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_wr_en && !w_rd_en) begin
            r_count <= r_count + CntWidth'(1);
         end else if (w_rd_en && !w_wr_en) begin
            r_count <= r_count - CntWidth'(1);
         end
      end
   end

   // Storage carries no reset; validity is tracked entirely by r_count.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

`ifdef XLS_FIFO_LEVEL_EN
   assign level = r_count;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst) begin
         if (r_count > C_FULL) begin
            $error("xls_fifo_wrapper_multi: occupancy %0d exceeds depth %0d", r_count, Depth);
         end
         if (w_push_fire && (r_count == C_FULL)) begin
            $error("xls_fifo_wrapper_multi: push accepted while full");
         end
      end
   end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_xls_fifo_wrapper_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_xls_fifo_wrapper_multi
// Purpose  : Scoreboard bench for xls_fifo_wrapper_multi. Three instances
//            share one stimulus stream: Depth=4 no bypass, Depth=3 no bypass,
//            Depth=4 with bypass. Each keeps its own reference queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xls_fifo_wrapper_multi;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [7:0]      push_data = '0;
   logic            push_valid = 1'b0;
   logic            pop_ready = 1'b0;
   logic [2:0]      pr;
   logic [2:0]      pv;
   logic [2:0][7:0] pd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

`ifdef XLS_FIFO_LEVEL_EN
   logic [2:0] lv0;
   logic [1:0] lv1;
   logic [2:0] lv2;
`endif

   xls_fifo_wrapper_multi #(.Width(8), .Depth(4), .EnableBypass(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .push_ready(pr[0]), .push_data(push_data), .push_valid(push_valid),
      .pop_ready(pop_ready), .pop_data(pd[0]), .pop_valid(pv[0])
`ifdef XLS_FIFO_LEVEL_EN
      , .level(lv0)
`endif
   );

   xls_fifo_wrapper_multi #(.Width(8), .Depth(3), .EnableBypass(0)) u_dut1 (
      .clk(clk), .rst(rst),
      .push_ready(pr[1]), .push_data(push_data), .push_valid(push_valid),
      .pop_ready(pop_ready), .pop_data(pd[1]), .pop_valid(pv[1])
`ifdef XLS_FIFO_LEVEL_EN
      , .level(lv1)
`endif
   );

   xls_fifo_wrapper_multi #(.Width(8), .Depth(4), .EnableBypass(1)) u_dut2 (
      .clk(clk), .rst(rst),
      .push_ready(pr[2]), .push_data(push_data), .push_valid(push_valid),
      .pop_ready(pop_ready), .pop_data(pd[2]), .pop_valid(pv[2])
`ifdef XLS_FIFO_LEVEL_EN
      , .level(lv2)
`endif
   );

   function automatic int dep_of(input int i);
      return (i == 1) ? 3 : 4;
   endfunction

   function automatic bit byp_of(input int i);
      return (i == 2);
   endfunction

   task automatic chk(input string name, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual %0h required %0h at %0t", name, i, act, exp, $time);
      end
   endtask

   // Reference model: one unbounded-style FIFO per instance (64-entry ring,
   // far larger than any DUT), capacity limited only by the spec's depth rule.
   logic [7:0] mdat [3][64];
   int         mhead [3];
   int         msize [3];

   initial begin
      for (int i = 0; i < 3; i++) begin
         mhead[i] = 0;
         msize[i] = 0;
      end
   end

   // Monitor/scoreboard: evaluated mid-cycle when inputs are stable.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst) begin
            chk("rst_push_ready", i, 32'(pr[i]), 32'd0);
            chk("rst_pop_valid", i, 32'(pv[i]), 32'd0);
            mhead[i] = 0;
            msize[i] = 0;
         end else begin
            bit exp_pr;
            bit exp_pv;
            exp_pr = (msize[i] != dep_of(i));
            exp_pv = (msize[i] != 0) || (byp_of(i) && push_valid);
            chk("push_ready", i, 32'(pr[i]), 32'(exp_pr));
            chk("pop_valid", i, 32'(pv[i]), 32'(exp_pv));
`ifdef XLS_FIFO_LEVEL_EN
            begin
               logic [2:0] lvl;
               lvl = (i == 0) ? lv0 : (i == 1) ? {1'b0, lv1} : lv2;
               chk("level", i, 32'(lvl), 32'(msize[i]));
            end
`endif
            if (exp_pv) begin
               logic [7:0] exp_d;
               exp_d = (msize[i] != 0) ? mdat[i][mhead[i]] : push_data;
               chk("pop_data", i, 32'(pd[i]), 32'(exp_d));
            end
            // Enqueue before dequeue so an empty bypass transfer nets to zero.
            if (push_valid && exp_pr) begin
               mdat[i][(mhead[i] + msize[i]) % 64] = push_data;
               msize[i]++;
            end
            if (exp_pv && pop_ready) begin
               mhead[i] = (mhead[i] + 1) % 64;
               msize[i]--;
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [7:0] d, input bit r);
      @(posedge clk);
      #1;
      push_valid = v;
      push_data  = d;
      pop_ready  = r;
   endtask

   task automatic rst_immediate_check(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_push_ready"}, i, 32'(pr[i]), 32'd0);
         chk({tag, "_pop_valid"}, i, 32'(pv[i]), 32'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held for a few cycles, released away from the clock edge.
      #2;
      rst_immediate_check("reset");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0);

      // Fill with pop stalled: Depth=3 instance saturates one push earlier.
      drive(1'b1, 8'h11, 1'b0);
      drive(1'b1, 8'h22, 1'b0);
      drive(1'b1, 8'h33, 1'b0);
      drive(1'b1, 8'h44, 1'b0);
      drive(1'b1, 8'h55, 1'b0);
      // Pop while full and offering 0x55; it should enter on the next cycle.
      drive(1'b1, 8'h55, 1'b1);
      drive(1'b1, 8'h55, 1'b1);
      repeat (7) drive(1'b0, 8'h00, 1'b1);

      // Bypass probes: empty with consumer ready, then with consumer stalled.
      drive(1'b1, 8'hA5, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'hA5, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      repeat (3) drive(1'b0, 8'h00, 1'b1);

      // Continuous streaming exercises pointer wrap in the Depth=3 instance.
      for (int k = 0; k < 10; k++) drive(1'b1, 8'(8'h60 + k), 1'b1);
      repeat (5) drive(1'b0, 8'h00, 1'b1);

      // Randomised traffic, biased first towards filling, then draining.
      for (int k = 0; k < 400; k++) begin
         bit v;
         bit r;
         v = (k < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
         r = (k < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
         drive(v, 8'($urandom), r);
      end
      repeat (6) drive(1'b0, 8'h00, 1'b1);

      // Mid-stream reset with two entries queued.
      drive(1'b1, 8'hC1, 1'b0);
      drive(1'b1, 8'hC2, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 rst_immediate_check("midrst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) drive(1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 40; k++) drive($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1);
      repeat (6) drive(1'b0, 8'h00, 1'b1);

      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xls_fifo_wrapper_multi.md
Name: xls_fifo_wrapper_multi

Overview:
Parametrised-depth successor to the single-entry XLS channel FIFO. It provides a circular-buffer FIFO of Depth entries with ready/valid on both sides and optional combinational bypass when empty. It sits between XLS-generated procs in the zstd pipeline wherever a channel needs more than one slot of elasticity.

Parameters:
Width, 32, data bits per entry (>=1)
Depth, 4, number of storage entries (>=1; non-power-of-2 allowed)
EnableBypass, 0, 1 = push data may reach pop in the same cycle when FIFO is empty
AddrWidth, $clog2(Depth) or 1 if Depth==1 (localparam), pointer width
CntWidth, $clog2(Depth+1) (localparam), occupancy counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
push_ready  output  1  FIFO can accept push_data this cycle
push_data  input  Width  data to enqueue
push_valid  input  1  producer offers push_data
pop_ready  input  1  consumer accepts pop_data this cycle
pop_data  output  Width  head-of-queue data
pop_valid  output  1  pop_data is valid

Behaviour:
- State: mem[Depth], wr_ptr, rd_ptr (AddrWidth), count (CntWidth, 0..Depth).
- Reset (rst low, async): count=0, wr_ptr=0, rd_ptr=0. Memory not reset. While rst low: push_ready=0, pop_valid=0. First cycle after release: push_ready=1, pop_valid=0.
- push_ready = (count != Depth). Depends only on registered state, never on pop_ready.
- pop_valid = (count != 0) || (EnableBypass && count==0 && push_valid).
- pop_data = mem[rd_ptr] when count != 0; push_data when bypassing.
- push_fire = push_valid && push_ready; pop_fire = pop_valid && pop_ready.
- Pointer wrap: ptr == Depth-1 -> 0, else ptr+1. No reliance on power-of-2 overflow.
- Cycle update:
  - push_fire only: mem[wr_ptr]<=push_data, wr_ptr++, count++.
  - pop_fire only: rd_ptr++, count--.
  - both, count != 0: write and read; both pointers advance; count unchanged.
  - both, count==0 (bypass only): pass-through; no write, pointers and count unchanged.
  - neither: hold.
- Latency without bypass: push at cycle N visible on pop at N+1. With bypass and empty: 0 cycles.
- Full (count==Depth): push_ready=0; a pop that cycle frees a slot and push_ready=1 next cycle.
- Empty, no bypass: pop_valid=0 regardless of push_valid.
- Depth==1, EnableBypass=0: cycle-equivalent to the existing single-entry FIFO.
- Ordering strictly FIFO; no data loss or duplication under any valid/ready pattern.
- Reset asserted mid-operation: contents discarded immediately; outputs go to reset values asynchronously.

Optional Feature:
Macro XLS_FIFO_LEVEL_EN.
- Defined: extra output port level [CntWidth-1:0] = count (registered occupancy, 0 after reset, excludes bypassed transfers). Also adds simulation-only checks: $error if count exceeds Depth or if push_fire occurs while count==Depth.
- Not defined: no level port, no checks; behaviour otherwise identical.

Test Plan:
- Width=8, Depth=4, bypass off: reset, push 0x11,0x22,0x33,0x44 with pop_ready=0 -> push_ready drops to 0 after 4th push; pop yields 0x11..0x44 in order, pop_valid=0 afterwards.
- Depth=3 (non-pow2): stream 10 values with push_valid=1 and pop_ready=1 continuously -> 1-cycle latency, wrap past entry 2 correct, count steady at 1.
- Full plus simultaneous pop: fill Depth=4, then pop_ready=1 and push_valid=1 with 0x55 -> that cycle only pop fires (push_ready=0); 0x55 accepted next cycle, emerges after 0x22..0x44.
- EnableBypass=1, empty: push 0xA5 with pop_ready=1 -> pop_valid=1, pop_data=0xA5 same cycle, count stays 0; with pop_ready=0, 0xA5 is stored and shown next cycle.
- Assert rst low mid-stream with 2 entries queued -> pop_valid=0 and push_ready=0 immediately; after release FIFO empty, push_ready=1.
- XLS_FIFO_LEVEL_EN defined: level tracks 0,1,2,1,0 across push,push,pop,pop sequence.
